// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for fifo_push_arb (burst lock under FIFO_ARB_LOCK_EN)
package fifo_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
  localparam int BEAT_W = 8;
  function automatic int rr_next(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] id
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    id = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        id = idx;
      end
    end
  end
endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin FIFO push arbiter, burst lock under FIFO_ARB_LOCK_EN
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BUSW = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*BUSW-1:0]     data,
  output logic [NREQ-1:0]          gnt,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output logic [BUSW-1:0]          fifo_datain,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     locked
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] ptr, pid;
  logic [NREQ-1:0] mask;
  logic en;
`ifdef FIFO_ARB_LOCK_EN
  arb_state_t state;
  logic [IW-1:0] owner;
  logic [BEAT_W-1:0] beats;
  assign mask = state == LOCKED ? req & (NREQ'(1) << owner) : req;
  assign locked = rst && state == LOCKED;
`else
  logic unused_cfg;
  assign unused_cfg = ^{1'b0, lock, BEAT_W'(MAX_BURST)};
  assign mask = req;
  assign locked = 1'b0;
`endif
  assign en = rst && !fifo_full;
  rr_pick #(.N(NREQ)) u_pick (
    .req(mask),
    .ptr(ptr),
    .en(en),
    .gnt(gnt),
    .id(pid)
  );
  assign grant_id = pid;
  assign fifo_push = |gnt;
  assign fifo_datain = fifo_push ? data[int'(pid)*BUSW +: BUSW] : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      ptr <= '0;
`ifdef FIFO_ARB_LOCK_EN
      state <= IDLE;
      owner <= '0;
      beats <= '0;
`endif
    end else if (!fifo_full) begin
`ifdef FIFO_ARB_LOCK_EN
      if (state == LOCKED) begin
        if (req[owner]) beats <= beats + 1'b1;
        if (!req[owner] || !lock[owner] || beats + 1'b1 == BEAT_W'(MAX_BURST)) begin
          state <= IDLE;
          ptr <= IW'(rr_next(int'(owner), NREQ));
        end
      end else if (fifo_push) begin
        ptr <= IW'(rr_next(int'(pid), NREQ));
        if (lock[pid] && MAX_BURST > 1) begin
          state <= LOCKED;
          owner <= pid;
          beats <= BEAT_W'(1);
        end
      end
`else
      if (fifo_push) ptr <= IW'(rr_next(int'(pid), NREQ));
`endif
    end
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed plus randomized checks of fifo_push_arb against a behavioural model
module tb_fifo_push_arb;
  localparam int N = 4;
  localparam int BUSW = 32;
  localparam int MB = 3;
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, lock, gnt;
  logic [N*BUSW-1:0] data;
  logic fifo_full, fifo_push, locked;
  logic [BUSW-1:0] fifo_datain;
  logic [1:0] grant_id;
  int total = 0;
  int bad = 0;
  int mptr = 0, mown = 0, mbeats = 0;
  bit mlk = 1'b0;
  logic [1:0] seen_id;
  logic seen_push, seen_locked;
  fifo_push_arb #(.NREQ(N), .BUSW(BUSW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .lock(lock),
    .data(data),
    .gnt(gnt),
    .fifo_full(fifo_full),
    .fifo_push(fifo_push),
    .fifo_datain(fifo_datain),
    .grant_id(grant_id),
    .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic f, input logic rs);
    int w, bd;
    logic [N-1:0] eg;
    logic [BUSW-1:0] ed;
    @(negedge clk);
    req = r;
    lock = l;
    fifo_full = f;
    rst = rs;
    for (int i = 0; i < N; i++) data[i*BUSW +: BUSW] = $urandom;
    #1;
    w = -1;
    if (rs && !f) begin
      if (mlk) w = r[mown] ? mown : -1;
      else begin
        bd = N;
        for (int i = 0; i < N; i++)
          if (r[i] && ((i - mptr + N) % N) < bd) begin
            bd = (i - mptr + N) % N;
            w = i;
          end
      end
    end
    eg = '0;
    ed = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ed = data[w*BUSW +: BUSW];
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("push", 64'(fifo_push), 64'(w >= 0));
    chk("datain", 64'(fifo_datain), 64'(ed));
    chk("grant_id", 64'(grant_id), 64'(w < 0 ? 0 : w));
    chk("locked", 64'(locked), 64'(rs && mlk));
    seen_id = grant_id;
    seen_push = fifo_push;
    seen_locked = locked;
    @(posedge clk);
    if (!rs) begin
      mptr = 0;
      mlk = 1'b0;
      mown = 0;
      mbeats = 0;
    end else if (!f) begin
      if (mlk) begin
        if (r[mown]) mbeats++;
        if (!r[mown] || !l[mown] || mbeats == MB) begin
          mlk = 1'b0;
          mptr = (mown + 1) % N;
        end
      end else if (w >= 0) begin
        mptr = (w + 1) % N;
        if (LOCK_EN && l[w] && MB > 1) begin
          mlk = 1'b1;
          mown = w;
          mbeats = 1;
        end
      end
    end
  endtask
  initial begin
    req = '0;
    lock = '0;
    fifo_full = 1'b0;
    rst = 1'b0;
    data = '0;
    cyc(4'b1111, 4'b0000, 1'b0, 1'b0);
    chk("reset_push", 64'(seen_push), 64'd0);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(4'b1111, 4'b0000, 1'b0, 1'b1);
      chk("rotation_id", 64'(seen_id), 64'(k % 4));
    end
    cyc(4'b0001, 4'b0000, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b0110, 4'b0000, 1'b1, 1'b1);
      chk("full_push", 64'(seen_push), 64'd0);
    end
    cyc(4'b0110, 4'b0000, 1'b0, 1'b1);
    chk("full_release_id1", 64'(seen_id), 64'd1);
    cyc(4'b0110, 4'b0000, 1'b0, 1'b1);
    chk("full_release_id2", 64'(seen_id), 64'd2);
`ifdef FIFO_ARB_LOCK_EN
    cyc(4'b1111, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 4'b0001, 1'b0, 1'b1);
      chk("burst_id", 64'(seen_id), 64'(k < 3 ? 0 : 1));
      chk("burst_locked", 64'(seen_locked), 64'(k == 1 || k == 2));
    end
    cyc(4'b1111, 4'b0100, 1'b0, 1'b1);
    chk("unlock_id_a", 64'(seen_id), 64'd2);
    cyc(4'b1111, 4'b0100, 1'b0, 1'b1);
    chk("unlock_id_b", 64'(seen_id), 64'd2);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b1);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b1);
    chk("unlock_next_id", 64'(seen_id), 64'd3);
    cyc(4'b1111, 4'b0001, 1'b0, 1'b1);
    cyc(4'b1111, 4'b0001, 1'b0, 1'b0);
    chk("midburst_reset_push", 64'(seen_push), 64'd0);
    cyc(4'b1000, 4'b0000, 1'b0, 1'b1);
    chk("post_reset_id", 64'(seen_id), 64'd3);
    chk("post_reset_locked", 64'(seen_locked), 64'd0);
    cyc(4'b1111, 4'b0000, 1'b0, 1'b1);
    chk("post_reset_wrap", 64'(seen_id), 64'd0);
`else
    for (int k = 0; k < 4; k++) begin
      cyc(4'b0100, 4'b1111, 1'b0, 1'b1);
      chk("single_id", 64'(seen_id), 64'd2);
      chk("single_locked", 64'(seen_locked), 64'd0);
    end
`endif
    for (int k = 0; k < 2000; k++)
      cyc(N'($urandom), ($urandom_range(0, 1) == 0) ? N'($urandom) : '1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 63) != 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
